lsr_window_feeder: RTL and testbench
====================================

// Module: lsr_window_feeder
// PURPOSE
//  Upstream feeder for the least-squares regression stage. Accepts a stream of
//  16-bit samples over a valid/ready handshake into a circular buffer of
//  DATA_SIZE entries. When the buffer holds a full window, and again after every
//  STRIDE further samples, it snapshots the window into a stable output register.
//  With the snapshot it gives the window's x-offset (shift) and pulses start so
//  the regression stage can fit it.
// PARAMETERS
//  DATA_SIZE  16  samples per window (>=2)
//  DATA_W     16  sample width in bits
//  STRIDE     1   new samples between consecutive launches (1..DATA_SIZE)
// PORTS
//  clk          in   1                   single clock, rising edge
//  rst_n        in   1                   asynchronous active-low reset
//  in_valid     in   1                   sample present on in_data
//  in_data      in   DATA_W              sample value
//  in_ready     out  1                   feeder accepts a sample this cycle
//  flush        in   1                   synchronous clear of window history
//  fit_busy     in   1                   regression stage still working; inhibits launch
//  window_data  out  DATA_SIZE*DATA_W    snapshot; entry i at [i*DATA_W +: DATA_W], i=0 oldest
//  shift        out  16                  absolute index of window_data entry 0, mod 2^16
//  start        out  1                   one-cycle pulse: snapshot and shift are valid
//  fill_level   out  $clog2(DATA_SIZE+1) number of valid samples in the buffer
// BEHAVIOUR
//  - Reset (rst_n=0, async): window_data=0, shift=0, start=0, fill_level=0.
//    Also clears wr_ptr, stride_cnt, abs_idx and pending, and the state returns to FILL.
//    in_ready=1 as soon as reset releases.
//  - Accept = in_valid & in_ready. On accept, in_data goes to buf[wr_ptr].
//    wr_ptr wraps from DATA_SIZE-1 to 0, and abs_idx (16b) increments with
//    natural wrap.
//  - in_ready = !pending (combinational from a register). No sample is accepted
//    while a launch is pending.
//  - States:
//    FILL: fill_level < DATA_SIZE. Each accept increments fill_level.
//      The accept that makes fill_level==DATA_SIZE sets pending and moves to PEND.
//    STREAM: buffer full. Each accept increments stride_cnt.
//      The accept that makes stride_cnt==STRIDE clears stride_cnt, sets pending
//      and moves to PEND.
//    PEND: in_ready=0. In any cycle with fit_busy=0, at the next edge:
//      - window_data takes buf reordered oldest-first, starting at wr_ptr
//        (equal to the oldest entry when full);
//      - shift <= abs_idx - DATA_SIZE (mod 2^16);
//      - start <= 1 and pending <= 0;
//      - the state moves to STREAM.
//      While fit_busy=1 the state stays PEND with no accepts.
//  - Latency: the accept that completes a window is followed by start=1 exactly
//    one cycle later if fit_busy=0, otherwise one cycle after fit_busy falls.
//  - start is high for exactly one cycle per launch and is never asserted in FILL.
//    window_data and shift change only on the edge that sets start, and then stay
//    stable until the next launch.
//  - flush=1 (sync) clears fill_level, wr_ptr, stride_cnt, abs_idx and pending,
//    and returns to FILL. window_data and shift keep their values. flush takes
//    priority over a simultaneous accept (the sample is dropped) and over a
//    launch (no start).
//  - Reset or flush while in PEND discards the pending launch. No start pulse
//    follows.
//  - STRIDE==DATA_SIZE gives non-overlapping windows. STRIDE==1 launches after
//    every sample once full.
// TESTING (DATA_SIZE=4, STRIDE=2 unless noted)
//  1. fit_busy=0, feed 1,2,3,4 back-to-back -> in_ready=0 one cycle;
//     start=1 next cycle; window={1,2,3,4}; shift=0; no start earlier.
//  2. Continue with 5,6 -> second start; window={3,4,5,6}; shift=2;
//     sample 5 alone produces no start.
//  3. Hold fit_busy=1 through window completion for 10 cycles -> in_ready=0,
//     start=0 throughout; drop fit_busy -> start 1 cycle later, window unchanged.
//  4. STRIDE=1, stream 65540 samples -> shift wraps 65535->0; start every 2 cycles.
//  5. Assert rst_n=0 in PEND, then flush in FILL after 3 samples -> no start;
//     fill_level=0; next window needs 4 new samples and starts at shift=0.
//  6. flush coincident with the 4th accept -> sample dropped, no start, fill_level=0.

Source files
------------

// File: rtl/lsr_window_feeder.sv
// Sample feeder for the least-squares regression stage: buffers a sliding window
// of samples and launches an ordered snapshot plus its absolute x-offset.
module lsr_window_feeder #(
  parameter int DATA_SIZE = 16,
  parameter int DATA_W    = 16,
  parameter int STRIDE    = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [DATA_W-1:0]                in_data,
  output logic                             in_ready,
  input  logic                             flush,
  input  logic                             fit_busy,
  output logic [DATA_SIZE*DATA_W-1:0]      window_data,
  output logic [15:0]                      shift,
  output logic                             start,
  output logic [$clog2(DATA_SIZE+1)-1:0]   fill_level
);

  localparam int PTR_W = $clog2(DATA_SIZE);
  localparam int CNT_W = $clog2(DATA_SIZE+1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_STREAM = 2'd1,
    ST_PEND   = 2'd2
  } state_e;

  state_e                        state_q;
  logic [DATA_W-1:0]             mem_q [DATA_SIZE];
  logic [PTR_W-1:0]              wr_ptr_q;
  logic [PTR_W-1:0]              wr_ptr_d;
  logic [CNT_W-1:0]              fill_q;
  logic [CNT_W-1:0]              stride_q;
  logic [15:0]                   abs_idx_q;
  logic                          pending_q;
  logic                          start_q;
  logic [15:0]                   shift_q;
  logic [DATA_SIZE*DATA_W-1:0]   window_q;
  logic [DATA_SIZE*DATA_W-1:0]   window_d;
  logic [PTR_W:0]                rd_idx_s;
  logic                          accept_s;

  assign in_ready    = ~pending_q;
  assign accept_s    = in_valid & ~pending_q;
  assign window_data = window_q;
  assign shift       = shift_q;
  assign start       = start_q;
  assign fill_level  = fill_q;

  // Circular write pointer advance.
  always_comb begin
    if (wr_ptr_q == PTR_W'(DATA_SIZE-1)) begin
      wr_ptr_d = {PTR_W{1'b0}};
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
  end

  // Reorder the ring oldest-first; once full, wr_ptr points at the oldest entry.
  always_comb begin
    window_d = {(DATA_SIZE*DATA_W){1'b0}};
    rd_idx_s = {(PTR_W+1){1'b0}};
    for (int i = 0; i < DATA_SIZE; i++) begin
      rd_idx_s = {1'b0, wr_ptr_q} + (PTR_W+1)'(i);
      if (rd_idx_s >= (PTR_W+1)'(DATA_SIZE)) begin
        rd_idx_s = rd_idx_s - (PTR_W+1)'(DATA_SIZE);
      end else begin
        rd_idx_s = rd_idx_s;
      end
      window_d[i*DATA_W +: DATA_W] = mem_q[rd_idx_s[PTR_W-1:0]];
    end
  end

  // Window control FSM with buffer writes and registered launch outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      wr_ptr_q  <= {PTR_W{1'b0}};
      fill_q    <= {CNT_W{1'b0}};
      stride_q  <= {CNT_W{1'b0}};
      abs_idx_q <= 16'd0;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      shift_q   <= 16'd0;
      window_q  <= {(DATA_SIZE*DATA_W){1'b0}};
      for (int i = 0; i < DATA_SIZE; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      start_q <= 1'b0;
      if (flush) begin
        // Flush wins over a coincident accept or launch; snapshot is retained.
        state_q   <= ST_FILL;
        wr_ptr_q  <= {PTR_W{1'b0}};
        fill_q    <= {CNT_W{1'b0}};
        stride_q  <= {CNT_W{1'b0}};
        abs_idx_q <= 16'd0;
        pending_q <= 1'b0;
      end else begin
        if (accept_s) begin
          mem_q[wr_ptr_q] <= in_data;
          wr_ptr_q        <= wr_ptr_d;
          abs_idx_q       <= abs_idx_q + 16'd1;
        end
        case (state_q)
          ST_FILL: begin
            if (accept_s) begin
              fill_q <= fill_q + CNT_W'(1);
              if (fill_q == CNT_W'(DATA_SIZE-1)) begin
                pending_q <= 1'b1;
                state_q   <= ST_PEND;
              end
            end
          end
          ST_STREAM: begin
            if (accept_s) begin
              if (stride_q == CNT_W'(STRIDE-1)) begin
                stride_q  <= {CNT_W{1'b0}};
                pending_q <= 1'b1;
                state_q   <= ST_PEND;
              end else begin
                stride_q <= stride_q + CNT_W'(1);
              end
            end
          end
          ST_PEND: begin
            if (!fit_busy) begin
              window_q  <= window_d;
              shift_q   <= abs_idx_q - 16'(DATA_SIZE);
              start_q   <= 1'b1;
              pending_q <= 1'b0;
              state_q   <= ST_STREAM;
            end
          end
          default: begin
            state_q   <= ST_FILL;
            pending_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsr_window_feeder.sv
// Directed bench for lsr_window_feeder: a 4/2 main instance, a 4/1 instance for
// per-sample launches and a 16/16 instance for the shift wrap.
module tb_lsr_window_feeder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        a_valid, a_ready, a_flush, a_busy, a_start;
  logic [15:0] a_data, a_shift;
  logic [63:0] a_win;
  logic [2:0]  a_fill;

  logic        b_valid, b_ready, b_flush, b_busy, b_start;
  logic [15:0] b_data, b_shift;
  logic [63:0] b_win;
  logic [2:0]  b_fill;

  logic         c_valid, c_ready, c_flush, c_busy, c_start;
  logic [15:0]  c_data, c_shift;
  logic [255:0] c_win;
  logic [4:0]   c_fill;

  lsr_window_feeder #(.DATA_SIZE(4), .DATA_W(16), .STRIDE(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .flush(a_flush), .fit_busy(a_busy), .window_data(a_win), .shift(a_shift),
    .start(a_start), .fill_level(a_fill));

  lsr_window_feeder #(.DATA_SIZE(4), .DATA_W(16), .STRIDE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .flush(b_flush), .fit_busy(b_busy), .window_data(b_win), .shift(b_shift),
    .start(b_start), .fill_level(b_fill));

  lsr_window_feeder #(.DATA_SIZE(16), .DATA_W(16), .STRIDE(16)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .flush(c_flush), .fit_busy(c_busy), .window_data(c_win), .shift(c_shift),
    .start(c_start), .fill_level(c_fill));

  function automatic logic [63:0] pack4(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] d, input logic f, input logic b);
    a_valid = v; a_data = d; a_flush = f; a_busy = b;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_valid = 1'b0; a_data = 16'd0; a_flush = 1'b0; a_busy = 1'b0;
    b_valid = 1'b0; b_data = 16'd0; b_flush = 1'b0; b_busy = 1'b0;
    c_valid = 1'b0; c_data = 16'd0; c_flush = 1'b0; c_busy = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (a_win !== 64'd0) begin n_bad++; $display("FAIL rst_window: got %h want 0", a_win); end
    n_cmp++; if (a_shift !== 16'd0) begin n_bad++; $display("FAIL rst_shift: got %0d want 0", a_shift); end
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL rst_start: got %0b want 0", a_start); end
    n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL rst_fill: got %0d want 0", a_fill); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0b want 1", a_ready); end
  endtask

  task automatic test_first_window();
    for (int k = 1; k <= 4; k++) begin
      drive_a(1'b1, 16'(k), 1'b0, 1'b0);
      n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t1_early_start k=%0d: got %0b want 0", k, a_start); end
      n_cmp++; if (a_fill !== 3'(k)) begin n_bad++; $display("FAIL t1_fill k=%0d: got %0d want %0d", k, a_fill, k); end
    end
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL t1_ready_pend: got %0b want 0", a_ready); end
    drive_a(1'b1, 16'd5, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b1) begin n_bad++; $display("FAIL t1_start: got %0b want 1", a_start); end
    n_cmp++; if (a_win !== pack4(16'd1, 16'd2, 16'd3, 16'd4)) begin n_bad++; $display("FAIL t1_window: got %h want %h", a_win, pack4(16'd1, 16'd2, 16'd3, 16'd4)); end
    n_cmp++; if (a_shift !== 16'd0) begin n_bad++; $display("FAIL t1_shift: got %0d want 0", a_shift); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL t1_ready_back: got %0b want 1", a_ready); end
  endtask

  task automatic test_stride_window();
    drive_a(1'b1, 16'd5, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t2_start_after5: got %0b want 0", a_start); end
    n_cmp++; if (a_fill !== 3'd4) begin n_bad++; $display("FAIL t2_fill: got %0d want 4", a_fill); end
    drive_a(1'b1, 16'd6, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t2_start_after6: got %0b want 0", a_start); end
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL t2_ready_pend: got %0b want 0", a_ready); end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b1) begin n_bad++; $display("FAIL t2_start: got %0b want 1", a_start); end
    n_cmp++; if (a_win !== pack4(16'd3, 16'd4, 16'd5, 16'd6)) begin n_bad++; $display("FAIL t2_window: got %h want %h", a_win, pack4(16'd3, 16'd4, 16'd5, 16'd6)); end
    n_cmp++; if (a_shift !== 16'd2) begin n_bad++; $display("FAIL t2_shift: got %0d want 2", a_shift); end
  endtask

  task automatic test_fit_busy();
    drive_a(1'b1, 16'd7, 1'b0, 1'b1);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t3_start_after7: got %0b want 0", a_start); end
    drive_a(1'b1, 16'd8, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      drive_a(1'b1, 16'd99, 1'b0, 1'b1);
      n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL t3_busy_ready c=%0d: got %0b want 0", c, a_ready); end
      n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t3_busy_start c=%0d: got %0b want 0", c, a_start); end
    end
    n_cmp++; if (a_win !== pack4(16'd3, 16'd4, 16'd5, 16'd6)) begin n_bad++; $display("FAIL t3_window_held: got %h want %h", a_win, pack4(16'd3, 16'd4, 16'd5, 16'd6)); end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b1) begin n_bad++; $display("FAIL t3_start: got %0b want 1", a_start); end
    n_cmp++; if (a_win !== pack4(16'd5, 16'd6, 16'd7, 16'd8)) begin n_bad++; $display("FAIL t3_window: got %h want %h", a_win, pack4(16'd5, 16'd6, 16'd7, 16'd8)); end
    n_cmp++; if (a_shift !== 16'd4) begin n_bad++; $display("FAIL t3_shift: got %0d want 4", a_shift); end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t3_start_pulse: got %0b want 0", a_start); end
  endtask

  task automatic test_reset_flush();
    drive_a(1'b1, 16'd9, 1'b0, 1'b0);
    drive_a(1'b1, 16'd10, 1'b0, 1'b0);
    n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL t5_pend: got %0b want 0", a_ready); end
    a_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL t5_async_fill: got %0d want 0", a_fill); end
    n_cmp++; if (a_win !== 64'd0) begin n_bad++; $display("FAIL t5_async_window: got %h want 0", a_win); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL t5_async_ready: got %0b want 1", a_ready); end
    step();
    rst_n = 1'b1;
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t5_no_start_rst: got %0b want 0", a_start); end
    for (int k = 11; k <= 13; k++) drive_a(1'b1, 16'(k), 1'b0, 1'b0);
    n_cmp++; if (a_fill !== 3'd3) begin n_bad++; $display("FAIL t5_fill3: got %0d want 3", a_fill); end
    drive_a(1'b0, 16'd0, 1'b1, 1'b0);
    n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL t5_flush_fill: got %0d want 0", a_fill); end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t5_no_start_flush: got %0b want 0", a_start); end
    for (int k = 21; k <= 24; k++) begin
      drive_a(1'b1, 16'(k), 1'b0, 1'b0);
      n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t5_early_start k=%0d: got %0b want 0", k, a_start); end
    end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b1) begin n_bad++; $display("FAIL t5_start: got %0b want 1", a_start); end
    n_cmp++; if (a_win !== pack4(16'd21, 16'd22, 16'd23, 16'd24)) begin n_bad++; $display("FAIL t5_window: got %h want %h", a_win, pack4(16'd21, 16'd22, 16'd23, 16'd24)); end
    n_cmp++; if (a_shift !== 16'd0) begin n_bad++; $display("FAIL t5_shift: got %0d want 0", a_shift); end
  endtask

  task automatic test_flush_accept();
    drive_a(1'b0, 16'd0, 1'b1, 1'b0);
    n_cmp++; if (a_win !== pack4(16'd21, 16'd22, 16'd23, 16'd24)) begin n_bad++; $display("FAIL t6_window_kept: got %h want %h", a_win, pack4(16'd21, 16'd22, 16'd23, 16'd24)); end
    n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL t6_fill0: got %0d want 0", a_fill); end
    for (int k = 31; k <= 33; k++) drive_a(1'b1, 16'(k), 1'b0, 1'b0);
    drive_a(1'b1, 16'd34, 1'b1, 1'b0);
    n_cmp++; if (a_fill !== 3'd0) begin n_bad++; $display("FAIL t6_fill_drop: got %0d want 0", a_fill); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL t6_ready: got %0b want 1", a_ready); end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t6_no_start: got %0b want 0", a_start); end
    for (int k = 41; k <= 44; k++) drive_a(1'b1, 16'(k), 1'b0, 1'b0);
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b1) begin n_bad++; $display("FAIL t6_start: got %0b want 1", a_start); end
    n_cmp++; if (a_win !== pack4(16'd41, 16'd42, 16'd43, 16'd44)) begin n_bad++; $display("FAIL t6_window: got %h want %h", a_win, pack4(16'd41, 16'd42, 16'd43, 16'd44)); end
    n_cmp++; if (a_shift !== 16'd0) begin n_bad++; $display("FAIL t6_shift: got %0d want 0", a_shift); end
    drive_a(1'b1, 16'd45, 1'b0, 1'b0);
    drive_a(1'b1, 16'd46, 1'b0, 1'b0);
    drive_a(1'b0, 16'd0, 1'b1, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t6_flush_launch: got %0b want 0", a_start); end
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL t6_flush_pend: got %0b want 1", a_ready); end
    drive_a(1'b0, 16'd0, 1'b0, 1'b0);
    n_cmp++; if (a_start !== 1'b0) begin n_bad++; $display("FAIL t6_late_start: got %0b want 0", a_start); end
    n_cmp++; if (a_win !== pack4(16'd41, 16'd42, 16'd43, 16'd44)) begin n_bad++; $display("FAIL t6_window_kept2: got %h want %h", a_win, pack4(16'd41, 16'd42, 16'd43, 16'd44)); end
  endtask

  // Samples carry their own absolute index, so window entry 0 must equal shift.
  task automatic test_stride1();
    int   k;
    logic exp_start;
    logic [15:0] exp_shift;
    k = 0;
    for (int c = 1; c <= 24; c++) begin
      b_valid = 1'b1;
      b_data  = 16'(k);
      if (b_ready === 1'b1) k++;
      step();
      exp_start = (c >= 5) && (c % 2 == 1);
      exp_shift = 16'((c - 5) / 2);
      n_cmp++; if (b_start !== exp_start) begin n_bad++; $display("FAIL t4_start c=%0d: got %0b want %0b", c, b_start, exp_start); end
      if (exp_start) begin
        n_cmp++; if (b_shift !== exp_shift) begin n_bad++; $display("FAIL t4_shift c=%0d: got %0d want %0d", c, b_shift, exp_shift); end
        n_cmp++; if (b_win !== pack4(exp_shift, exp_shift + 16'd1, exp_shift + 16'd2, exp_shift + 16'd3)) begin
          n_bad++; $display("FAIL t4_window c=%0d: got %h want %h", c, b_win, pack4(exp_shift, exp_shift + 16'd1, exp_shift + 16'd2, exp_shift + 16'd3));
        end
      end
    end
    b_valid = 1'b0;
  endtask

  task automatic test_shift_wrap();
    int   k;
    logic exp_pend;
    logic exp_start;
    logic acc;
    logic [15:0] exp_shift;
    bit   done;
    k = 0; exp_pend = 1'b0; done = 1'b0;
    for (int c = 0; c < 75000 && !done; c++) begin
      n_cmp++; if (c_ready !== !exp_pend) begin n_bad++; $display("FAIL wrap_ready c=%0d: got %0b want %0b", c, c_ready, !exp_pend); end
      acc       = !exp_pend;
      exp_start = exp_pend;
      c_valid   = 1'b1;
      c_data    = 16'(k);
      step();
      if (exp_start) exp_pend = 1'b0;
      if (acc) begin
        k++;
        if (k % 16 == 0) exp_pend = 1'b1;
      end
      n_cmp++; if (c_start !== exp_start) begin n_bad++; $display("FAIL wrap_start c=%0d: got %0b want %0b", c, c_start, exp_start); end
      if (exp_start) begin
        exp_shift = 16'(k - 16);
        n_cmp++; if (c_shift !== exp_shift) begin n_bad++; $display("FAIL wrap_shift k=%0d: got %0d want %0d", k, c_shift, exp_shift); end
        n_cmp++; if (c_win[15:0] !== exp_shift || c_win[255:240] !== exp_shift + 16'd15) begin
          n_bad++; $display("FAIL wrap_window k=%0d: got %h..%h want %h..%h", k, c_win[15:0], c_win[255:240], exp_shift, exp_shift + 16'd15);
        end
        if (k > 65536 && exp_shift == 16'd0) done = 1'b1;
      end
    end
    c_valid = 1'b0;
    n_cmp++; if (!done) begin n_bad++; $display("FAIL wrap_timeout: got no wrapped launch want shift 0 after 65536 samples"); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_stride_window();
    test_fit_busy();
    test_reset_flush();
    test_flush_accept();
    test_stride1();
    test_shift_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
